// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux scan sampler.
// State encoding is exported so benches can decode the debug state port.
package mux_scan_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/mux_scan_sampler_timer.sv
// settle_timer: loadable down-counter that stops at zero and flags it.
// Load has priority over decrement.
module settle_timer
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Drives the mux select through channels a..d, samples w after SETTLE cycles
// on each, and offers the assembled 4-bit word on a valid/ready handshake.
module mux_scan_sampler
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       w,
   output logic       s1,
   output logic       s0,
   output logic       busy,
   output logic [3:0] data,
   output logic       valid,
   input  logic       ready,
   output logic [1:0] dbg_state
);

   // Handshake: data transfers at a rising edge where valid && ready; valid
   // never drops without a transfer and data is stable while valid is high.

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NCH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [2:0]       r_shadow;
   logic [3:0]       r_data;
   logic             r_valid;
   logic             r_busy;

   logic w_zero;
   logic w_load;
   logic w_dec;
   logic w_accept;
   logic w_sample;
   logic w_finish;
   logic w_handshake;

   settle_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (LOAD_VAL),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      w_finish    = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_load      = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!w_zero) begin
               w_dec = 1'b1;
            end else begin
               w_sample = 1'b1;
               if (r_sel == LAST_CH) begin
                  w_finish    = 1'b1;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            // start is deliberately not looked at here, even on the handshake edge
            if (r_valid && ready) begin
               w_handshake = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel    <= '0;
         r_shadow <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sel  <= '0;
            r_busy <= 1'b1;
         end
         if (w_sample && !w_finish) begin
            r_shadow[r_sel] <= w;
            r_sel           <= r_sel + 1'b1;
         end
         if (w_finish) begin
            r_data  <= {w, r_shadow};
            r_valid <= 1'b1;
         end
         if (w_handshake) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_sel   <= '0;
         end
      end
   end

   assign s1        = r_sel[1];
   assign s0        = r_sel[0];
   assign busy      = r_busy;
   assign data      = r_data;
   assign valid     = r_valid;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: the bench plays the mux (drives w per
// channel by its own timing) and scoreboards each expected word until handshake.
module tb_mux_scan_sampler;

   localparam int P   = 2;
   localparam int NCH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       w;
   logic       s1;
   logic       s0;
   logic       busy;
   logic [3:0] data;
   logic       valid;
   logic       ready;
   logic [1:0] dbg_state;

   logic [3:0] exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   mux_scan_sampler #(.SETTLE(P)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .w         (w),
      .s1        (s1),
      .s0        (s0),
      .busy      (busy),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full scan starting from IDLE at a negedge. glitch drives the wrong
   // value on every non-sample cycle; hold delays ready after valid rises;
   // poke_start pulses start mid-scan and on the handshake edge.
   task automatic scan(input logic [3:0] word, input bit glitch, input int hold,
                       input bit poke_start);
      logic [3:0] exp_word;
      start = 1'b1;
      ready = (hold == 0);
      exp_q.push_back(word);
      @(negedge clk);
      start = 1'b0;
      check("busy_on", busy, 1);
      for (int ch = 0; ch < NCH; ch++) begin
         for (int c = 0; c < P; c++) begin
            check("sel_seq", {s1, s0}, ch);
            check("valid_early", valid, 0);
            w     = (c == P - 1 || !glitch) ? word[ch] : ~word[ch];
            start = poke_start && (ch == 1) && (c == 0);
            @(negedge clk);
         end
      end
      start = 1'b0;
      check("valid_on", valid, 1);
      check("sel_hold", {s1, s0}, 3);
      for (int i = 0; i < hold; i++) begin
         w = 1'($urandom_range(0, 1));
         check("bp_valid", valid, 1);
         check("bp_busy", busy, 1);
         check("bp_data", data, exp_q[0]);
         @(negedge clk);
      end
      ready = 1'b1;
      start = poke_start;
      check("q_nonempty", exp_q.size() != 0, 1);
      exp_word = exp_q.pop_front();
      check("data", data, exp_word);
      @(negedge clk);
      start = 1'b0;
      ready = 1'b0;
      check("valid_off", valid, 0);
      check("busy_off", busy, 0);
      check("sel_idle", {s1, s0}, 0);
      check("data_kept", data, exp_word);
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_valid", valid, 0);
         check("idle_state", dbg_state, 0);
      end
      ready = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      w     = 1'b0;
      #2;
      check("rst_sel", {s1, s0}, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      scan(4'b1001, 1'b0, 0, 1'b0);
      scan(4'b1110, 1'b0, 5, 1'b0);
      scan(4'b0101, 1'b1, 2, 1'b0);
      scan(4'b1100, 1'b0, 1, 1'b1);
      idle_check(4);

      // Abort a scan while channel 2 is selected.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2 * P + 1; i++) begin
         w = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      check("pre_rst_sel", {s1, s0}, 2);
      rst = 1'b1;
      #1;
      check("mid_rst_sel", {s1, s0}, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_data", data, 0);
      check("mid_rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      scan(4'b1011, 1'b0, 0, 1'b0);

      for (int k = 0; k < 3; k++) begin
         scan(4'($urandom_range(0, 15)), 1'b1, $urandom_range(0, 3), 1'b0);
      end
      idle_check(2);
      check("q_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
